// File: rtl/slu_pkg.sv
// Shared opcodes, widths and FSM state encoding for the bit-serial logic unit.
package slu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   // Codes 6 and 7 are reserved and flagged as errors.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= OP_NOR;
   endfunction

endpackage

// File: rtl/bit_serial_logic_unit_if.sv
// Operand/result handshake bundle between the datapath and the bit-serial logic unit.
interface bit_serial_logic_unit_if #(parameter int WIDTH = 8);
   import slu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             err;
   logic             busy;
   logic             parity;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, err, busy, parity
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, err, busy, parity
   );

endinterface

// File: rtl/bit_serial_logic_unit_cell.sv
// Two-input gate primitives and the one-bit logic cell that selects among them by opcode.
module and_gate (input logic a, input logic b, output logic y);
   assign y = a & b;
endmodule

module or_gate (input logic a, input logic b, output logic y);
   assign y = a | b;
endmodule

module not_gate (input logic a, output logic y);
   assign y = ~a;
endmodule

module xor_gate (input logic a, input logic b, output logic y);
   assign y = a ^ b;
endmodule

module nand_gate (input logic a, input logic b, output logic y);
   assign y = ~(a & b);
endmodule

module nor_gate (input logic a, input logic b, output logic y);
   assign y = ~(a | b);
endmodule

module bit_logic_cell
   import slu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic            a,
   input  logic            b,
   output logic            y
);

   logic and_y, or_y, not_y, xor_y, nand_y, nor_y;

   and_gate  u_and  (.a(a), .b(b), .y(and_y));
   or_gate   u_or   (.a(a), .b(b), .y(or_y));
   not_gate  u_not  (.a(a),         .y(not_y));
   xor_gate  u_xor  (.a(a), .b(b), .y(xor_y));
   nand_gate u_nand (.a(a), .b(b), .y(nand_y));
   nor_gate  u_nor  (.a(a), .b(b), .y(nor_y));

   // Reserved opcodes produce a zero bit so an illegal op can never leak data.
   always_comb begin
      y = 1'b0;
      case (op)
         OP_AND:  y = and_y;
         OP_OR:   y = or_y;
         OP_NOT:  y = not_y;
         OP_XOR:  y = xor_y;
         OP_NAND: y = nand_y;
         OP_NOR:  y = nor_y;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial logic unit: one result bit per clock, LSB first, through a single bit_logic_cell.
// Optional macro SLU_PARITY_EN adds a running parity register for the result.
module bit_serial_logic_unit
   import slu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   bit_serial_logic_unit_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] res_q;
   logic             err_q;
   logic             out_valid_q;
   logic             cell_bit;
`ifdef SLU_PARITY_EN
   logic             parity_q;
`endif

   bit_logic_cell u_cell (
      .op (op_q),
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .y  (cell_bit)
   );

   // Operands shift right so the current bit is always at index 0; the result
   // fills from the MSB so it lands bit-aligned after WIDTH shifts. An illegal
   // op parks in DONE for one cycle before out_valid rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         op_q        <= '0;
         res_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SLU_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  op_q  <= bus.op;
                  cnt   <= '0;
                  res_q <= '0;
                  err_q <= !op_legal(bus.op);
`ifdef SLU_PARITY_EN
                  parity_q <= 1'b0;
`endif
                  state <= op_legal(bus.op) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               res_q <= {cell_bit, res_q[WIDTH-1:1]};
`ifdef SLU_PARITY_EN
               parity_q <= parity_q ^ cell_bit;
`endif
               if (cnt == CW'(WIDTH - 1)) begin
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = res_q;
   assign bus.err       = err_q;
`ifdef SLU_PARITY_EN
   assign bus.parity    = parity_q;
`else
   assign bus.parity    = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Self-checking bench for bit_serial_logic_unit: directed table, random ops against a
// parallel reference model, backpressure and mid-run reset sequences.
module tb_bit_serial_logic_unit;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   bit_serial_logic_unit_if #(.WIDTH(W)) ifc ();

   bit_serial_logic_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_result;
      logic         exp_err;
   } vec_t;

   // Parallel reference: the whole word at once, {err, result}.
   function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      case (op)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, ~a};
         3'd3:    return {1'b0, a ^ b};
         3'd4:    return {1'b0, ~(a & b)};
         3'd5:    return {1'b0, ~(a | b)};
         default: return {1'b1, {W{1'b0}}};
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Issues one operation from IDLE, checks latency and the held result for
   // `hold` extra cycles of backpressure, then consumes it.
   task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] exp_result,
                                 input logic exp_err, input int hold);
      int lat;
      int exp_lat;
      logic exp_par;
      exp_lat = exp_err ? 1 : W;
`ifdef SLU_PARITY_EN
      exp_par = ^exp_result;
`else
      exp_par = 1'b0;
`endif
      check_output("in_ready_before_issue", 32'(ifc.in_ready), 32'd1);
      ifc.op        = op;
      ifc.a         = a;
      ifc.b         = b;
      ifc.in_valid  = 1'b1;
      ifc.out_ready = 1'b0;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ifc.a        = W'($urandom);
      ifc.b        = W'($urandom);
      lat = 0;
      for (int k = 1; k <= W + 4; k++) begin
         @(posedge clk);
         #1;
         if (ifc.out_valid) begin
            lat = k;
            break;
         end
      end
      check_output("latency", 32'(lat), 32'(exp_lat));
      if (lat == 0) return;
      check_output("result", 32'(ifc.result), 32'(exp_result));
      check_output("err", 32'(ifc.err), 32'(exp_err));
      check_output("parity", 32'(ifc.parity), 32'(exp_par));
      check_output("busy_done", 32'(ifc.busy), 32'd1);
      check_output("in_ready_done", 32'(ifc.in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         ifc.in_valid = h[0];
         ifc.op       = 3'($urandom);
         @(posedge clk);
         #1;
         check_output("hold_result", 32'(ifc.result), 32'(exp_result));
         check_output("hold_valid", 32'(ifc.out_valid), 32'd1);
         check_output("hold_in_ready", 32'(ifc.in_ready), 32'd0);
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
      check_output("valid_after_consume", 32'(ifc.out_valid), 32'd0);
      check_output("in_ready_after_consume", 32'(ifc.in_ready), 32'd1);
   endtask

   vec_t table_v[$];
   logic [W:0] m;

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      ifc.op        = '0;
      ifc.a         = '0;
      ifc.b         = '0;

      table_v.push_back('{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0});
      table_v.push_back('{3'd4, 8'hF0, 8'h3C, 8'hCF, 1'b0});
      table_v.push_back('{3'd2, 8'hA5, 8'hFF, 8'h5A, 1'b0});
      table_v.push_back('{3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0});
      table_v.push_back('{3'd1, 8'h01, 8'h02, 8'h03, 1'b0});
      table_v.push_back('{3'd1, 8'h01, 8'h00, 8'h01, 1'b0});
      table_v.push_back('{3'd5, 8'h81, 8'h10, 8'h6E, 1'b0});
      table_v.push_back('{3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1});
      table_v.push_back('{3'd0, 8'hFF, 8'h81, 8'h81, 1'b0});
      table_v.push_back('{3'd7, 8'h12, 8'h34, 8'h00, 1'b1});

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_in_ready", 32'(ifc.in_ready), 32'd1);
      check_output("reset_out_valid", 32'(ifc.out_valid), 32'd0);
      check_output("reset_busy", 32'(ifc.busy), 32'd0);
      check_output("reset_result", 32'(ifc.result), 32'd0);
      check_output("reset_err", 32'(ifc.err), 32'd0);
      check_output("reset_parity", 32'(ifc.parity), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (table_v[i])
         apply_stimulus(table_v[i].op, table_v[i].a, table_v[i].b,
                        table_v[i].exp_result, table_v[i].exp_err, 0);

      $display("[TB] backpressure sequence");
      apply_stimulus(3'd3, 8'h5C, 8'h33, 8'h6F, 1'b0, 5);

      $display("[TB] mid-run reset sequence");
      ifc.op       = 3'd1;
      ifc.a        = 8'hFF;
      ifc.b        = 8'h00;
      ifc.in_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
      check_output("midreset_busy", 32'(ifc.busy), 32'd0);
      check_output("midreset_result", 32'(ifc.result), 32'd0);
      check_output("midreset_in_ready", 32'(ifc.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(3'd0, 8'hAA, 8'h0F, 8'h0A, 1'b0, 0);

      $display("[TB] random sequence");
      for (int r = 0; r < 40; r++) begin
         logic [2:0]   rop;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         rop = 3'($urandom_range(0, 7));
         ra  = W'($urandom);
         rb  = W'($urandom);
         m   = model(rop, ra, rb);
         apply_stimulus(rop, ra, rb, m[W-1:0], m[W], r % 7 == 3 ? 2 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
